// File: rtl/game_pkg.sv
// Shared types, sizes and element helpers for the pattern playback controller.
package game_pkg;

    localparam int unsigned MAX_LEN   = 25;
    localparam int unsigned ELEM_W    = 3;
    localparam int unsigned PATTERN_W = 75;
    localparam int unsigned LEN_W     = 5;
    localparam int unsigned LED_W     = 8;
    localparam int unsigned DWELL_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } play_state_e;

    // Requested lengths beyond the history depth play the full history.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    // Constant-index mux keeps every part-select statically in range.
    function automatic logic [LED_W-1:0] elem_onehot(input logic [PATTERN_W-1:0] pat,
                                                     input logic [LEN_W-1:0]     idx);
        logic [ELEM_W-1:0] elem;
        elem = '0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (idx == LEN_W'(k)) elem = pat[k*ELEM_W +: ELEM_W];
        end
        return LED_W'(1) << elem;
    endfunction

endpackage

// File: rtl/pattern_playback_ctrl_if.sv
// Command and display bundle between a playback requester and the controller.
interface pattern_playback_ctrl_if;
    import game_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 reverse;
    logic [LEN_W-1:0]     length;
    logic [PATTERN_W-1:0] pattern;
    logic [LED_W-1:0]     led;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, reverse, length, pattern,
        input  led, busy, done
    );

    modport slave (
        input  start, abort, reverse, length, pattern,
        output led, busy, done
    );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire_c is high once the count has reached zero.
module dwell_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_value,
    output logic               expire_c
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expire_c = (count == '0);

endmodule

// File: rtl/pattern_playback_ctrl.sv
// Plays a captured 3-bit element history on a one-hot LED bank with lit/dark
// dwell per element, then pulses done.
module pattern_playback_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst,
    pattern_playback_ctrl_if.slave bus
);

    // Timer counts down to zero, so a load of N-1 gives N cycles in the state.
    localparam logic [DWELL_W-1:0] ON_LOAD  = DWELL_W'(ON_CYCLES - 1);
    localparam logic [DWELL_W-1:0] OFF_LOAD = DWELL_W'(OFF_CYCLES - 1);

    play_state_e          state, state_next;
    logic [PATTERN_W-1:0] pat_q, pat_next;
    logic                 rev_q, rev_next;
    logic [LEN_W-1:0]     len_q, len_next;
    logic [LEN_W-1:0]     idx_q, idx_next;
    logic [LED_W-1:0]     led_q, led_next;
    logic                 busy_q, busy_next;
    logic                 done_q, done_next;

    logic                 timer_load;
    logic [DWELL_W-1:0]   timer_value;
    logic                 expire_c;
    logic [LEN_W-1:0]     start_len;
    logic                 last_elem;

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expire_c   (expire_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pat_q  <= '0;
            rev_q  <= 1'b0;
            len_q  <= '0;
            idx_q  <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            pat_q  <= pat_next;
            rev_q  <= rev_next;
            len_q  <= len_next;
            idx_q  <= idx_next;
            led_q  <= led_next;
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    // Outputs are computed for the next cycle and registered above.
    always_comb begin
        state_next  = state;
        pat_next    = pat_q;
        rev_next    = rev_q;
        len_next    = len_q;
        idx_next    = idx_q;
        led_next    = '0;
        busy_next   = 1'b1;
        done_next   = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        start_len   = clamp_len(bus.length);
        last_elem   = rev_q ? (idx_q == len_q - LEN_W'(1)) : (idx_q == '0);

        unique case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (bus.start && !bus.abort) begin
                    pat_next  = bus.pattern;
                    rev_next  = bus.reverse;
                    len_next  = start_len;
                    busy_next = 1'b1;
                    if (start_len == '0) begin
                        state_next = ST_DONE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_SHOW;
                        idx_next   = bus.reverse ? '0 : start_len - LEN_W'(1);
                        led_next   = elem_onehot(bus.pattern, idx_next);
                    end
                end
            end
            ST_SHOW: begin
                if (expire_c) state_next = ST_GAP;
                else          led_next   = elem_onehot(pat_q, idx_q);
            end
            ST_GAP: begin
                if (expire_c) begin
                    if (last_elem) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_SHOW;
                        idx_next   = rev_q ? idx_q + LEN_W'(1) : idx_q - LEN_W'(1);
                        led_next   = elem_onehot(pat_q, idx_next);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        if (bus.abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            led_next   = '0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
        end

        // Dwell restarts on every state entry.
        if (state_next != state) begin
            timer_load = 1'b1;
            unique case (state_next)
                ST_SHOW: timer_value = ON_LOAD;
                ST_GAP:  timer_value = OFF_LOAD;
                default: timer_value = '0;
            endcase
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_pattern_playback_ctrl.sv
// Directed self-checking bench for pattern_playback_ctrl with ON=4, OFF=2.
module tb_pattern_playback_ctrl;

    localparam int ON     = 4;
    localparam int OFF    = 2;
    localparam int PERIOD = ON + OFF;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [2:0] exp_seq [25];

    pattern_playback_ctrl_if ifc ();

    pattern_playback_ctrl #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LED in cycle c after the start edge for an n-element playback.
    function automatic logic [7:0] exp_led(input int c, input int n);
        logic [7:0] one;
        one = 8'h01;
        if (c < 1 || c > n * PERIOD) return 8'h00;
        if (((c - 1) % PERIOD) < ON) return one << exp_seq[(c - 1) / PERIOD];
        return 8'h00;
    endfunction

    task automatic drive_start(input logic [4:0] len, input logic [74:0] pat, input logic rev);
        @(negedge clk);
        ifc.length  = len;
        ifc.pattern = pat;
        ifc.reverse = rev;
        ifc.start   = 1'b1;
        @(negedge clk);
        ifc.start   = 1'b0;
    endtask

    function automatic logic [74:0] pat_531();
        logic [74:0] p;
        p = '0;
        p[8:0] = {3'd5, 3'd0, 3'd7};
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ifc.led !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", ifc.led); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifc.done); end
        rst = 1'b0;
        drive_start(5'd3, pat_531(), 1'b0);
        @(negedge clk);
        checks++; if (ifc.led !== 8'h20) begin errors++; $display("FAIL reset_pre_led got %h exp 20", ifc.led); end
        rst = 1'b1;
        #1;
        checks++; if (ifc.led !== 8'h00) begin errors++; $display("FAIL midrst_led got %h exp 00", ifc.led); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", ifc.done); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
                errors++; $display("FAIL postrst_idle c=%0d got done=%b busy=%b exp 0 0", c, ifc.done, ifc.busy);
            end
        end
        exp_seq[0] = 3'd3;
        drive_start(5'd1, 75'd3, 1'b0);
        for (int c = 1; c <= PERIOD + 2; c++) begin
            checks++; if (ifc.led !== exp_led(c, 1)) begin errors++; $display("FAIL postrst_led c=%0d got %h exp %h", c, ifc.led, exp_led(c, 1)); end
            checks++; if (ifc.done !== (c == PERIOD + 1)) begin errors++; $display("FAIL postrst_done c=%0d got %b", c, ifc.done); end
            checks++; if (ifc.busy !== (c <= PERIOD + 1)) begin errors++; $display("FAIL postrst_busy c=%0d got %b", c, ifc.busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_forward();
        exp_seq[0] = 3'd5; exp_seq[1] = 3'd0; exp_seq[2] = 3'd7;
        drive_start(5'd3, pat_531(), 1'b0);
        // Inputs scrambled after start must not affect the playback.
        ifc.pattern = '1;
        ifc.length  = 5'd1;
        ifc.reverse = 1'b1;
        for (int c = 1; c <= 3 * PERIOD + 3; c++) begin
            checks++; if (ifc.led !== exp_led(c, 3)) begin errors++; $display("FAIL fwd_led c=%0d got %h exp %h", c, ifc.led, exp_led(c, 3)); end
            checks++; if (ifc.done !== (c == 3 * PERIOD + 1)) begin errors++; $display("FAIL fwd_done c=%0d got %b", c, ifc.done); end
            checks++; if (ifc.busy !== (c <= 3 * PERIOD + 1)) begin errors++; $display("FAIL fwd_busy c=%0d got %b", c, ifc.busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_reverse();
        exp_seq[0] = 3'd7; exp_seq[1] = 3'd0; exp_seq[2] = 3'd5;
        drive_start(5'd3, pat_531(), 1'b1);
        for (int c = 1; c <= 3 * PERIOD + 2; c++) begin
            checks++; if (ifc.led !== exp_led(c, 3)) begin errors++; $display("FAIL rev_led c=%0d got %h exp %h", c, ifc.led, exp_led(c, 3)); end
            checks++; if (ifc.done !== (c == 3 * PERIOD + 1)) begin errors++; $display("FAIL rev_done c=%0d got %b", c, ifc.done); end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_length();
        drive_start(5'd0, pat_531(), 1'b0);
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL zero_busy1 got %b exp 1", ifc.busy); end
        checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL zero_done1 got %b exp 1", ifc.done); end
        checks++; if (ifc.led !== 8'h00) begin errors++; $display("FAIL zero_led1 got %h exp 00", ifc.led); end
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL zero_busy2 got %b exp 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL zero_done2 got %b exp 0", ifc.done); end
    endtask

    task automatic test_abort();
        exp_seq[0] = 3'd5; exp_seq[1] = 3'd0; exp_seq[2] = 3'd7;
        drive_start(5'd3, pat_531(), 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++; if (ifc.led !== exp_led(c, 3)) begin errors++; $display("FAIL abort_led c=%0d got %h exp %h", c, ifc.led, exp_led(c, 3)); end
            if (c == 3) begin ifc.start = 1'b1; ifc.pattern = '1; ifc.reverse = 1'b1; end
            if (c == 4) ifc.start = 1'b0;
            if (c == 8) ifc.abort = 1'b1;
            @(negedge clk);
        end
        ifc.abort = 1'b0;
        checks++; if (ifc.led !== 8'h00) begin errors++; $display("FAIL abort_led_after got %h exp 00", ifc.led); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got %b exp 0", ifc.busy); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
                errors++; $display("FAIL abort_quiet c=%0d got done=%b busy=%b exp 0 0", c, ifc.done, ifc.busy);
            end
        end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        ifc.length = 5'd3; ifc.pattern = pat_531(); ifc.reverse = 1'b0;
        ifc.start  = 1'b1; ifc.abort = 1'b1;
        @(negedge clk);
        ifc.start  = 1'b0; ifc.abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (ifc.busy !== 1'b0 || ifc.led !== 8'h00) begin
                errors++; $display("FAIL abort_start c=%0d got busy=%b led=%h exp 0 00", c, ifc.busy, ifc.led);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        logic [74:0] pat;
        int n;
        pat = '0;
        n = 25;
        for (int k = 0; k < 25; k++) pat[3*k +: 3] = 3'((k * 3 + 1) % 8);
        for (int i = 0; i < 25; i++) exp_seq[i] = 3'(((24 - i) * 3 + 1) % 8);
        drive_start(5'd31, pat, 1'b0);
        for (int c = 1; c <= n * PERIOD + 2; c++) begin
            checks++; if (ifc.led !== exp_led(c, n)) begin errors++; $display("FAIL clamp_led c=%0d got %h exp %h", c, ifc.led, exp_led(c, n)); end
            checks++; if (ifc.done !== (c == 151)) begin errors++; $display("FAIL clamp_done c=%0d got %b", c, ifc.done); end
            checks++; if (ifc.busy !== (c <= 151)) begin errors++; $display("FAIL clamp_busy c=%0d got %b", c, ifc.busy); end
            @(negedge clk);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        ifc.start   = 1'b0;
        ifc.abort   = 1'b0;
        ifc.reverse = 1'b0;
        ifc.length  = '0;
        ifc.pattern = '0;
        for (int i = 0; i < 25; i++) exp_seq[i] = '0;
        test_reset();
        test_forward();
        test_reverse();
        test_zero_length();
        test_abort();
        test_abort_start_idle();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_playback_ctrl.md
PATTERN_PLAYBACK_CTRL -- requirements
Module: pattern_playback_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 4: clock cycles each element's LED is lit; legal range 1..65535.
REQ-002 Parameter OFF_CYCLES, default 2: dark cycles after each element; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin playback; honoured only in IDLE.
REQ-006 abort  input  1  terminates playback; no done pulse is issued.
REQ-007 reverse  input  1  0 = oldest element first, 1 = newest element first; sampled with start.
REQ-008 length  input  5  number of 3-bit elements to play, 0..31.
REQ-009 pattern  input  75  packed element history; newest element in [2:0], element k (0 = newest) in [3k+2:3k].
REQ-010 led  output  8  registered one-hot display of the current element; 0 when dark.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when playback completes normally.

Function
REQ-013 The FSM SHALL have states IDLE, SHOW, GAP and DONE.
REQ-014 IDLE with start=1 and abort=0: capture pattern, reverse and the clamped length; go to SHOW if length>0, otherwise go to DONE.
REQ-015 Clamp: a length above 25 SHALL be treated as 25.
REQ-016 Captured values SHALL be frozen for the whole playback; later input changes SHALL be ignored.
REQ-017 Order, reverse=0: elements N-1 down to 0 (oldest first); reverse=1: elements 0 up to N-1.
REQ-018 SHOW: led = 1 << element value for exactly ON_CYCLES cycles, then go to GAP.
REQ-019 GAP: led = 0 for exactly OFF_CYCLES cycles, then go to SHOW for the next element, or go to DONE after the last element.
REQ-020 DONE: done=1 and led=0 for one cycle, then go to IDLE.
REQ-021 Latency: with start sampled at edge t, led SHALL be valid from cycle t+1, and done SHALL be high in cycle t+1+N*(ON_CYCLES+OFF_CYCLES).
REQ-022 abort=1 in any non-IDLE state: next state IDLE, led=0, busy=0, no done pulse.
REQ-023 abort=1 and start=1 together in IDLE: abort wins and playback does not start.
REQ-024 start while busy SHALL be ignored; no re-trigger and no queuing.
REQ-025 The dwell counter SHALL be 16 bits and reload at every state entry; the element index SHALL be 5 bits and never leave the range 0..N-1.

Reset
REQ-026 While rst=1: state=IDLE, led=0, busy=0, done=0, and all counters and captured registers are 0.
REQ-027 Reset asserted mid-playback SHALL abandon playback immediately with no done pulse; the first start after deassertion behaves normally.

Structure
REQ-028 Shared package game_pkg SHALL hold: playback state enum, MAX_LEN=25, ELEM_W=3, PATTERN_W=75.
REQ-029 One sub-module, dwell_timer, SHALL implement the loadable 16-bit down-counter with an expire flag; all other logic stays in the top level.

Verification (ON_CYCLES=4, OFF_CYCLES=2)
REQ-030 Reset: rst=1 mid-SHOW -> led=0x00, busy=0, done=0 immediately; no done pulse afterward.
REQ-031 length=3, pattern[8:0]={5,0,7}, reverse=0, start at t -> led 0x20 for t+1..t+4, 0x00 for two cycles, 0x01, 0x00, 0x80, 0x00; done at t+19 only.
REQ-032 Same stimulus with reverse=1 -> led sequence 0x80, 0x01, 0x20; done at t+19.
REQ-033 length=0, start at t -> busy=1 and done=1 at t+1; led stays 0x00; IDLE at t+2.
REQ-034 abort during the second SHOW of the REQ-031 case -> led=0 and busy=0 next cycle; no done; start pulses during playback ignored.
REQ-035 length=31, start at t -> exactly 25 elements shown; done at t+151.
